alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: W, default 3, operand width and opcode width; W SHALL be >= 3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
REQ-006 cmd_op  input  W  operation, encoded with the alu_ops package constants.
REQ-007 cmd_a, cmd_b  input  W each  operands.
REQ-008 cmd_chain  input  1  when 1, operand a is replaced by the last completed result.
REQ-009 cmd_use_carry  input  1  when 1, alu_c_in is driven from the stored carry flag, else 0.
REQ-010 alu_opcode, alu_a, alu_b  output  W each  registered drive to the ALU.
REQ-011 alu_c_in  output  1  registered carry-in to the ALU.
REQ-012 alu_y  input  W  ALU result; alu_c_out, alu_v, alu_n, alu_z  input  1 each  ALU flags.
REQ-013 rsp_valid  output  1  response available; rsp_ready  input  1  response consumed.
REQ-014 rsp_y  output  W  captured result; rsp_flags  output  4  {c, v, n, z}.
REQ-015 rsp_err  output  1  the command carried an opcode outside the seven alu_ops constants.
REQ-016 flags_q  output  4  flags of the last completed non-error operation.
REQ-017 op_count  output  8  saturating count of completed responses.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on accept, load alu_opcode=cmd_op, alu_a=(cmd_chain ? last result : cmd_a), alu_b=cmd_b, alu_c_in=(cmd_use_carry ? flags_q[3] : 0), then go to EXEC.
REQ-020 EXEC: lasts exactly one cycle; at its closing edge capture alu_y and the four ALU flags into rsp_y/rsp_flags, set rsp_valid=1, go to RESP.
REQ-021 Latency: rsp_valid SHALL rise exactly two clk edges after the accepting edge.
REQ-022 Illegal opcode: rsp_err=1, rsp_y=0, rsp_flags=0; flags_q and the last-result register SHALL NOT update.
REQ-023 Legal opcode: at the EXEC capture edge, flags_q <= captured flags and last result <= alu_y.
REQ-024 RESP: rsp_valid, rsp_y, rsp_flags, rsp_err held stable until rsp_valid && rsp_ready; on that edge rsp_valid=0, op_count increments (holds at 255), and the FSM goes to IDLE.
REQ-025 alu_* outputs SHALL hold their loaded values from accept until the next accept.
REQ-026 cmd_* inputs SHALL be ignored outside the accepting edge.
REQ-027 cmd_chain on the first command after reset SHALL use last result = 0.

Reset
REQ-028 While rst_n=0: state IDLE; cmd_ready=1 one edge-independent (combinational from state); rsp_valid=0, rsp_err=0, rsp_y=0, rsp_flags=0, flags_q=0, op_count=0, last result=0, alu_opcode=alu_a=alu_b=0, alu_c_in=0.
REQ-029 Reset asserted in EXEC or RESP SHALL abort the operation immediately, with no response and no counter increment.

Verification (W=3, bench connects the team alu to the alu_* ports)
REQ-030 AND_OP, a=110, b=011, rsp_ready=1 -> rsp_valid two edges after accept, rsp_y=010, rsp_err=0, op_count=1.
REQ-031 Then OR_OP, cmd_chain=1, cmd_a=111, b=001 -> alu_a=010, rsp_y=011.
REQ-032 rsp_ready=0 for 3 cycles in RESP -> rsp_* stable, cmd_ready=0 throughout, cmd_valid pulses ignored; the response completes on the first rsp_ready=1 edge.
REQ-033 Opcode not among the seven alu_ops constants -> rsp_err=1, rsp_y=000, rsp_flags=0000, flags_q unchanged.
REQ-034 rst_n pulsed low during EXEC -> rsp_valid never asserted, all outputs at reset values, next command completes normally.
REQ-035 260 back-to-back commands -> op_count saturates at 255.

Source files
------------

// File: rtl/alu_sequencer.sv
// Opcode constants shared by the sequencer and the ALU it drives.
// Seven legal operations occupy codes 0..6; every other code is illegal.
// Widened with a size cast wherever the operand width exceeds three bits.
package alu_ops;
    localparam logic [2:0] AND_OP = 3'd0;
    localparam logic [2:0] OR_OP  = 3'd1;
    localparam logic [2:0] XOR_OP = 3'd2;
    localparam logic [2:0] ADD_OP = 3'd3;
    localparam logic [2:0] SUB_OP = 3'd4;
    localparam logic [2:0] SHL_OP = 3'd5;
    localparam logic [2:0] SHR_OP = 3'd6;
endpackage

// Sequences one command at a time through an external ALU and returns a response.
// Latency: ALU drive loaded on the accepting edge, response valid on the next edge.
// Backpressure: cmd_ready only in IDLE; a response is held until rsp_ready.
module alu_sequencer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_chain,
    input  logic         cmd_use_carry,
    output logic [W-1:0] alu_opcode,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_c_in,
    input  logic [W-1:0] alu_y,
    input  logic         alu_c_out,
    input  logic         alu_v,
    input  logic         alu_n,
    input  logic         alu_z,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_y,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic [3:0]   flags_q,
    output logic [7:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  last_y;
    logic          op_legal;

    // Ready is a pure decode of the state so it is valid even while in reset.
    assign cmd_ready = (state == IDLE);

    // The opcode register is held from accept, so legality is judged on it at capture.
    assign op_legal = (alu_opcode == W'(alu_ops::AND_OP)) ||
                      (alu_opcode == W'(alu_ops::OR_OP))  ||
                      (alu_opcode == W'(alu_ops::XOR_OP)) ||
                      (alu_opcode == W'(alu_ops::ADD_OP)) ||
                      (alu_opcode == W'(alu_ops::SUB_OP)) ||
                      (alu_opcode == W'(alu_ops::SHL_OP)) ||
                      (alu_opcode == W'(alu_ops::SHR_OP));

    // Control FSM: load ALU drive on accept, capture result after one cycle, hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_c_in   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_y      <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            flags_q    <= '0;
            last_y     <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_opcode <= cmd_op;
                        alu_a      <= cmd_chain ? last_y : cmd_a;
                        alu_b      <= cmd_b;
                        alu_c_in   <= cmd_use_carry ? flags_q[3] : 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                    if (op_legal) begin
                        rsp_y     <= alu_y;
                        rsp_flags <= {alu_c_out, alu_v, alu_n, alu_z};
                        rsp_err   <= 1'b0;
                        flags_q   <= {alu_c_out, alu_v, alu_n, alu_z};
                        last_y    <= alu_y;
                    end else begin
                        // Illegal opcode: zeroed response, architectural state untouched.
                        rsp_y     <= '0;
                        rsp_flags <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        if (op_count != 8'hFF) begin
                            op_count <= op_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with W=3 driving a behavioural ALU on its alu_* ports.
// Directed commands push hand-computed responses into a scoreboard queue;
// a separate monitor pops and compares on every response handshake.
module tb_alu_sequencer;
    import alu_ops::*;

    localparam int W = 3;

    typedef struct packed {
        logic [W-1:0] y;
        logic [3:0]   flags;
        logic         err;
    } rsp_t;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_chain;
    logic         cmd_use_carry;
    logic [W-1:0] alu_opcode;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_c_in;
    logic [W-1:0] alu_y;
    logic         alu_c_out;
    logic         alu_v;
    logic         alu_n;
    logic         alu_z;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_y;
    logic [3:0]   rsp_flags;
    logic         rsp_err;
    logic [3:0]   flags_q;
    logic [7:0]   op_count;

    logic [W:0]   alu_sum;

    rsp_t sb_q[$];
    int   checks;
    int   passes;

    alu_sequencer #(.W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_chain     (cmd_chain),
        .cmd_use_carry (cmd_use_carry),
        .alu_opcode    (alu_opcode),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_c_in      (alu_c_in),
        .alu_y         (alu_y),
        .alu_c_out     (alu_c_out),
        .alu_v         (alu_v),
        .alu_n         (alu_n),
        .alu_z         (alu_z),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_y         (rsp_y),
        .rsp_flags     (rsp_flags),
        .rsp_err       (rsp_err),
        .flags_q       (flags_q),
        .op_count      (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: combinational result and {c, v, n, z} flags.
    always_comb begin
        alu_sum   = '0;
        alu_y     = '0;
        alu_c_out = 1'b0;
        alu_v     = 1'b0;
        case (alu_opcode)
            AND_OP: alu_y = alu_a & alu_b;
            OR_OP:  alu_y = alu_a | alu_b;
            XOR_OP: alu_y = alu_a ^ alu_b;
            ADD_OP: begin
                alu_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_c_in};
                alu_y     = alu_sum[W-1:0];
                alu_c_out = alu_sum[W];
                alu_v     = (alu_a[W-1] == alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
            end
            SUB_OP: begin
                alu_sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
                alu_y     = alu_sum[W-1:0];
                alu_c_out = alu_sum[W];
                alu_v     = (alu_a[W-1] != alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
            end
            SHL_OP: begin
                alu_y     = {alu_a[W-2:0], 1'b0};
                alu_c_out = alu_a[W-1];
            end
            SHR_OP: begin
                alu_y     = {1'b0, alu_a[W-1:1]};
                alu_c_out = alu_a[0];
            end
            default: alu_y = '0;
        endcase
        alu_n = alu_y[W-1];
        alu_z = (alu_y == '0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"},  32'(cmd_ready),  32'd1);
        check({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
        check({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
        check({tag, "_rsp_y"},      32'(rsp_y),      32'd0);
        check({tag, "_rsp_flags"},  32'(rsp_flags),  32'd0);
        check({tag, "_flags_q"},    32'(flags_q),    32'd0);
        check({tag, "_op_count"},   32'(op_count),   32'd0);
        check({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
        check({tag, "_alu_a"},      32'(alu_a),      32'd0);
        check({tag, "_alu_b"},      32'(alu_b),      32'd0);
        check({tag, "_alu_c_in"},   32'(alu_c_in),   32'd0);
    endtask

    // Offers one command when ready; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic chain, input logic carry, input rsp_t exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("issue_wait_ready", 32'(cmd_ready), 32'd1);
        cmd_valid     = 1'b1;
        cmd_op        = op;
        cmd_a         = a;
        cmd_b         = b;
        cmd_chain     = chain;
        cmd_use_carry = carry;
        sb_q.push_back(exp);
        @(negedge clk);
        cmd_valid     = 1'b0;
        cmd_op        = 3'b111;
        cmd_a         = 3'b111;
        cmd_b         = 3'b111;
        cmd_chain     = 1'b0;
        cmd_use_carry = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("idle_wait_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
    endtask

    // Monitor: compares every consumed response against the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    check("rsp_y",     32'(rsp_y),     32'(e.y));
                    check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                    check("rsp_err",   32'(rsp_err),   32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks        = 0;
        passes        = 0;
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_op        = '0;
        cmd_a         = '0;
        cmd_b         = '0;
        cmd_chain     = 1'b0;
        cmd_use_carry = 1'b0;
        rsp_ready     = 1'b1;
        #1;
        check_reset_vals("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // AND 110 & 011 = 010; response appears at the second edge counting the accepting one.
        issue(AND_OP, 3'b110, 3'b011, 1'b0, 1'b0, '{y: 3'b010, flags: 4'b0000, err: 1'b0});
        check("lat_after_accept", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_second_edge", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("and_op_count", 32'(op_count), 32'd1);
        check("and_rsp_dropped", 32'(rsp_valid), 32'd0);

        // OR chained on last result 010 with b=001 -> 011; cmd_a=111 must be ignored.
        issue(OR_OP, 3'b111, 3'b001, 1'b1, 1'b0, '{y: 3'b011, flags: 4'b0000, err: 1'b0});
        check("chain_alu_a", 32'(alu_a), 32'b010);
        check("chain_alu_opcode", 32'(alu_opcode), 32'(OR_OP));
        wait_idle();

        // ADD 111 + 011 = 1010 -> y=010, carry out, no signed overflow.
        issue(ADD_OP, 3'b111, 3'b011, 1'b0, 1'b0, '{y: 3'b010, flags: 4'b1000, err: 1'b0});
        wait_idle();
        check("add_flags_q", 32'(flags_q), 32'b1000);

        // ADD with stored carry 001+001+1 = 011, response stalled three cycles.
        rsp_ready = 1'b0;
        issue(ADD_OP, 3'b001, 3'b001, 1'b0, 1'b1, '{y: 3'b011, flags: 4'b0000, err: 1'b0});
        check("carry_alu_c_in", 32'(alu_c_in), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_rsp_valid",  32'(rsp_valid),  32'd1);
            check("stall_rsp_y",      32'(rsp_y),      32'b011);
            check("stall_rsp_flags",  32'(rsp_flags),  32'b0000);
            check("stall_cmd_ready",  32'(cmd_ready),  32'd0);
            check("stall_alu_opcode", 32'(alu_opcode), 32'(ADD_OP));
            cmd_valid = 1'b1;
            cmd_op    = XOR_OP;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("stall_last_valid", 32'(rsp_valid), 32'd1);
        check("stall_op_count", 32'(op_count), 32'd3);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_done_valid", 32'(rsp_valid), 32'd0);
        check("stall_done_ready", 32'(cmd_ready), 32'd1);
        check("stall_done_count", 32'(op_count), 32'd4);
        check("stall_alu_a_held", 32'(alu_a), 32'b001);

        // ADD 111 + 001 = 000 with carry and zero.
        issue(ADD_OP, 3'b111, 3'b001, 1'b0, 1'b0, '{y: 3'b000, flags: 4'b1001, err: 1'b0});
        wait_idle();
        check("zero_flags_q", 32'(flags_q), 32'b1001);

        // Illegal opcode 111: zeroed response with error, flags_q kept.
        issue(3'b111, 3'b101, 3'b010, 1'b0, 1'b0, '{y: 3'b000, flags: 4'b0000, err: 1'b1});
        wait_idle();
        check("illegal_flags_q", 32'(flags_q), 32'b1001);
        check("illegal_op_count", 32'(op_count), 32'd6);

        // Reset pulsed while in EXEC: operation aborted, no response.
        issue(AND_OP, 3'b111, 3'b111, 1'b0, 1'b0, '{y: 3'b111, flags: 4'b0010, err: 1'b0});
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        check("abort_hold_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Chain after reset uses last result 0: 000 | 101 = 101, negative.
        issue(OR_OP, 3'b111, 3'b101, 1'b1, 1'b0, '{y: 3'b101, flags: 4'b0010, err: 1'b0});
        check("post_reset_chain_a", 32'(alu_a), 32'd0);
        wait_idle();
        check("post_reset_count", 32'(op_count), 32'd1);

        // 260 back-to-back commands saturate the counter.
        for (int i = 0; i < 260; i++) begin
            issue(AND_OP, 3'b000, 3'b000, 1'b0, 1'b0, '{y: 3'b000, flags: 4'b0001, err: 1'b0});
        end
        wait_idle();
        check("sat_op_count", 32'(op_count), 32'd255);
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
